rv32m_div_unit: RTL and testbench
=================================

Name: rv32m_div_unit

Overview:
Multi-cycle integer divider for the RV32IM execute stage. Implements DIV, DIVU, REM and REMU.
- Sits beside the ALU. Its result feeds the EX/MEM pipeline register through the execute-result mux.
- `busy` drives the hazard unit, which stalls PC, IF/ID and ID/EX while a divide is in flight.
- Radix-2 restoring algorithm, one quotient bit per cycle. Special cases take a 1-cycle fast path.

Parameters:
- XLEN, 32, operand and result width; iteration count equals XLEN.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-low; state is reset on a rising clk edge when reset=0.
- start  input  1  request a divide with the operands below; sampled only when busy=0.
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  XLEN  rs1 value after forwarding.
- divisor  input  XLEN  rs2 value after forwarding.
- flush  input  1  abort the in-flight operation; driven when the hazard unit flushes the execute stage.
- busy  output  1  operation in progress; hazard unit stalls the pipeline while high.
- valid  output  1  one-cycle pulse: result is ready.
- result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).

Behaviour:
- Reset (reset=0 at an edge): state IDLE, busy=0, valid=0, result=0, internal registers cleared. Applies from any state, including mid-CALC.
- States: IDLE, CALC, DONE.
- Accept rule: start is accepted at an edge when state is IDLE or DONE and flush=0. Back-to-back operations are allowed from DONE.
- Operand capture on accept: latch op and sign flags. For signed ops, latch absolute values. Clear the quotient and partial-remainder registers. Set count=0.
- Fast path, decided at the accept edge (state goes to DONE, result loaded at that edge):
  - divisor==0: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - DIV/REM with dividend=0x8000_0000 and divisor=0xFFFF_FFFF: DIV -> 0x8000_0000; REM -> 0.
  - Latency: valid=1 in the cycle after the accept edge.
- Normal path: IDLE/DONE -> CALC at the accept edge.
  - Each CALC edge: shift partial remainder left, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit, count++.
  - After XLEN iterations, the next edge applies the sign fix and loads result, then goes CALC -> DONE.
  - Sign fix: quotient is negated if dividend and divisor signs differ (signed ops only). Remainder takes the dividend's sign.
  - Latency: valid=1 exactly XLEN+2 cycles after the accept edge (cycle 34 for XLEN=32).
- busy=1 in CALC only; busy=0 in IDLE and DONE. busy asserts in the cycle after the accept edge.
- valid=1 only in DONE, for exactly one cycle. DONE -> IDLE on the next edge unless a new start is accepted.
- result holds its value until the next completion, including through IDLE.
- flush=1 at any edge in CALC: go to IDLE; valid never asserted for that operation; result unchanged.
- flush in DONE: go to IDLE.
- flush and start in the same cycle: flush wins and start is ignored.
- start while busy=1: ignored. Operand inputs are don't-care while in CALC.
- Arithmetic: partial remainder is XLEN+1 bits, so the trial subtraction never wraps. DIVU/REMU treat operands as unsigned.

Test Plan:
- DIV 100/7: result=14 (0x0000000E), valid at cycle 34, busy high cycles 1..33. REM 100/7: result=2.
- DIV -100/7: result=0xFFFFFFF2. REM -100/7: result=0xFFFFFFFE. REMU 0xFFFFFF9C/7: result=0x00000002.
- Divide by zero: DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x00001234; both valid at cycle 1, busy never high.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; 1-cycle latency. Also DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF at cycle 34.
- flush at cycle 10 of a CALC: busy=0 at cycle 11, no valid pulse, result keeps the prior value. Then a new DIV 9/3 -> 3.
- reset=0 at cycle 15 of a CALC: busy=0, valid=0, result=0 after that edge. A start asserted while busy=1 is ignored (result matches the first operands only). A back-to-back start in the DONE cycle is accepted.

Source files
------------

// File: rtl/rv32m_div_unit.sv
// rv32m_div_unit: multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
// Radix-2 restoring division produces one quotient bit per cycle. Divide by
// zero and signed overflow complete on a one-cycle fast path. busy stalls
// the front of the pipeline, and valid pulses once when result is updated.
module rv32m_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_dvd;      // |dividend|, shifted out MSB first
    logic [XLEN-1:0]   r_dvs;      // |divisor|
    logic [XLEN-1:0]   r_quo;      // quotient bits, shifted in LSB first
    logic [XLEN-1:0]   r_rem;      // partial remainder, always below r_dvs
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_rem;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_busy;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;

    // Operand decode at the accept edge
    logic              w_accept;
    logic              w_signed;
    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [XLEN-1:0]   w_dvd_abs;
    logic [XLEN-1:0]   w_dvs_abs;
    logic              w_div_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_fast_result;

    // A flush in the same cycle overrides start; start is ignored while in CALC.
    assign w_accept   = start && !flush && (r_state != S_CALC);
    assign w_signed   = !op[0];
    assign w_dvd_neg  = w_signed && dividend[XLEN-1];
    assign w_dvs_neg  = w_signed && divisor[XLEN-1];
    assign w_dvd_abs  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_abs  = w_dvs_neg ? -divisor : divisor;
    assign w_div_zero = (divisor == '0);
    assign w_ovf      = w_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

    // Divide by zero: quotient all ones, remainder = dividend.
    // Signed overflow: quotient = dividend (0x8000_0000), remainder = 0.
    assign w_fast_result = w_div_zero ? (op[1] ? dividend : '1)
                                      : (op[1] ? '0 : dividend);

    // One restoring step. The shifted remainder is XLEN+1 bits wide, so its
    // difference with the divisor never wraps. The MSB of the difference is
    // therefore a clean borrow flag.
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;

    assign w_shift = {r_rem, r_dvd[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = !w_diff[XLEN];

    // Sign fix: the quotient is negative when the operand signs differ, and
    // the remainder takes the sign of the dividend.
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;

    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    // Control FSM, datapath iteration and registered outputs
    // NOTE: all state in this block uses non-blocking assignments, so every
    // right-hand side sees the value from before the edge. Blocking assignments
    // here would create order-dependent races between the datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_W'(XLEN)) begin
                        r_result <= r_is_rem ? w_r_fix : w_q_fix;
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                    end else begin
                        r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_ge};
                        r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation. Otherwise,
                    // including on flush, the FSM returns to IDLE.
                    if (w_accept) begin
                        r_dvd    <= w_dvd_abs;
                        r_dvs    <= w_dvs_abs;
                        r_quo    <= '0;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_is_rem <= op[1];
                        r_neg_q  <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r  <= w_dvd_neg;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_fast_result;
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign valid  = r_valid;
    assign result = r_result;

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Directed testbench for rv32m_div_unit. Outputs are sampled on the falling
// clock edge. Cycle 1 is the clock period that follows the accept edge.
module tb_rv32m_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    rv32m_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .valid    (valid),
        .result   (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current falling edge. The task returns at the
    // falling edge of cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for valid. The task reports its cycle and the number of busy
    // cycles. If inj > 0, it drives a DIVU 50/5 start pulse in cycle inj.
    task automatic wait_done(input int inj, output int lat, output logic [31:0] res,
                             output int bcnt);
        lat  = 0;
        res  = 'x;
        bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) bcnt++;
            if (valid) begin
                lat = c;
                res = result;
                break;
            end
            if (c == inj) begin
                start    = 1'b1;
                op       = OP_DIVU;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy);
        int          lat;
        int          bcnt;
        logic [31:0] res;
        @(negedge clk);
        issue(o, a, b);
        wait_done(0, lat, res, bcnt);
        check({tag, " result"}, res, exp_res);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, bcnt, exp_busy);
    endtask

    initial begin
        int          lat;
        int          bcnt;
        int          vseen;
        logic [31:0] res;

        reset    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = OP_DIV;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset valid", valid, 1'b0);
        check("reset result", result, 32'h0);
        reset = 1'b1;

        // DIV 100/7. A start pulse during CALC must be ignored.
        @(negedge clk);
        issue(OP_DIV, 32'd100, 32'd7);
        check("busy in cycle 1", busy, 1'b1);
        wait_done(5, lat, res, bcnt);
        check("DIV 100/7 result", res, 32'h0000000E);
        check("DIV 100/7 latency", lat, 34);
        check("DIV 100/7 busy cycles", bcnt, 33);

        // Back-to-back: a start issued in the DONE cycle is accepted.
        issue(OP_REM, 32'd100, 32'd7);
        check("b2b busy", busy, 1'b1);
        wait_done(0, lat, res, bcnt);
        check("b2b REM 100/7 result", res, 32'h00000002);
        check("b2b REM 100/7 latency", lat, 34);

        run_op("DIV -100/7",  OP_DIV,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34, 33);
        run_op("REM -100/7",  OP_REM,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34, 33);
        run_op("REMU big/7",  OP_REMU, 32'hFFFFFF9C, 32'd7, 32'h00000002, 34, 33);
        run_op("DIVU x/0",    OP_DIVU, 32'h00001234, 32'd0, 32'hFFFFFFFF, 1, 0);
        run_op("REM x/0",     OP_REM,  32'h00001234, 32'd0, 32'h00001234, 1, 0);
        run_op("DIV ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("REM ovf",     OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);
        run_op("DIVU max/2",  OP_DIVU, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 34, 33);

        // Flush in cycle 10 of CALC: no valid pulse, and result keeps its value.
        @(negedge clk);
        issue(OP_DIV, 32'd100, 32'd7);
        vseen = 0;
        for (int c = 1; c <= 9; c++) begin
            if (valid) vseen++;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy cycle 11", busy, 1'b0);
        for (int c = 0; c < 40; c++) begin
            if (valid) vseen++;
            @(negedge clk);
        end
        check("flush no valid", vseen, 0);
        check("flush result kept", result, 32'h7FFFFFFF);

        // When flush and start are both high, flush wins.
        start    = 1'b1;
        flush    = 1'b1;
        op       = OP_DIV;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush+start busy", busy, 1'b0);
        check("flush+start valid", valid, 1'b0);

        run_op("DIV 9/3", OP_DIV, 32'd9, 32'd3, 32'h00000003, 34, 33);

        // Reset asserted in cycle 15 of CALC.
        @(negedge clk);
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid reset busy", busy, 1'b0);
        check("mid reset valid", valid, 1'b0);
        check("mid reset result", result, 32'h0);
        reset = 1'b1;

        run_op("DIVU 50/5", OP_DIVU, 32'd50, 32'd5, 32'h0000000A, 34, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
